// File: rtl/audio_dac_i2s_tx_if.sv
// audio_dac_i2s_tx_if: stereo PCM frame handshake into the I2S playback FIFO
// Signals: in_valid/in_ready handshake, in_left/in_right two's-complement samples.
// Modports: master drives frames, slave (the DAC block) returns in_ready.
`timescale 1ns/1ps
interface audio_dac_i2s_tx_if #(parameter int DATA_WIDTH = 24);
  logic in_valid;
  logic in_ready;
  logic [DATA_WIDTH-1:0] in_left;
  logic [DATA_WIDTH-1:0] in_right;
  modport master(output in_valid, in_left, in_right, input in_ready);
  modport slave(input in_valid, in_left, in_right, output in_ready);
endinterface

// File: rtl/audio_dac_i2s_tx.sv
// audio_dac_i2s_tx: FIFO-buffered stereo PCM to I2S DAC serialiser, codec is clock master
// Ports: clk_clk/reset_reset_n (async active-low) system clock and reset; enable playback;
//   s_in frame handshake (in_valid/in_ready/in_left/in_right); bclk_export and
//   dac_lr_clk_export asynchronous codec clocks (LR 0 = left); dac_data_export serial data;
//   fifo_level buffered frames; underflow sticky flag with clear_underflow.
// Option AUDIO_DAC_UNDERFLOW_CNT_EN adds a saturating 16-bit underflow_count output.
`timescale 1ns/1ps
module audio_dac_i2s_tx #(
  parameter int DATA_WIDTH = 24,
  parameter int FIFO_AW = 3
) (
  input  logic clk_clk,
  input  logic reset_reset_n,
  input  logic enable,
  audio_dac_i2s_tx_if.slave s_in,
  input  logic bclk_export,
  input  logic dac_lr_clk_export,
  output logic dac_data_export,
  output logic [FIFO_AW:0] fifo_level,
  output logic underflow,
  input  logic clear_underflow
`ifdef AUDIO_DAC_UNDERFLOW_CNT_EN
  ,
  output logic [15:0] underflow_count
`endif
);
  localparam int DEPTH = 2 ** FIFO_AW;
  localparam int CW = $clog2(DATA_WIDTH + 1);
  logic [1:0] bclk_sync, lr_sync;
  logic bclk_d, lr_prev, run;
  logic [DATA_WIDTH-1:0] sr, hold;
  logic [CW-1:0] bit_cnt;
  logic [FIFO_AW:0] wr_ptr, rd_ptr;
  logic [2*DATA_WIDTH-1:0] mem [DEPTH];
  logic [2*DATA_WIDTH-1:0] rd_data;
  logic fe, left_b, right_b, empty, full, push, pop, uf_ev;
  assign fe = bclk_d & ~bclk_sync[1];
  assign left_b = fe & ~lr_sync[1] & lr_prev;
  assign right_b = fe & lr_sync[1] & ~lr_prev;
  assign fifo_level = wr_ptr - rd_ptr;
  assign empty = wr_ptr == rd_ptr;
  // pointers differ only in the wrap bit when every slot is occupied
  assign full = (wr_ptr ^ rd_ptr) == {1'b1, {FIFO_AW{1'b0}}};
  assign s_in.in_ready = run & ~full;
  assign push = s_in.in_valid & s_in.in_ready;
  assign pop = left_b & enable & ~empty;
  assign uf_ev = left_b & enable & empty;
  assign rd_data = mem[rd_ptr[FIFO_AW-1:0]];
  always_ff @(posedge clk_clk)
    if (push) mem[wr_ptr[FIFO_AW-1:0]] <= {s_in.in_left, s_in.in_right};
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      bclk_sync <= '0;
      lr_sync <= '0;
      bclk_d <= 1'b0;
      lr_prev <= 1'b1;
      run <= 1'b0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      underflow <= 1'b0;
    end else begin
      bclk_sync <= {bclk_sync[0], bclk_export};
      lr_sync <= {lr_sync[0], dac_lr_clk_export};
      bclk_d <= bclk_sync[1];
      lr_prev <= fe ? lr_sync[1] : lr_prev;
      run <= 1'b1;
      wr_ptr <= wr_ptr + {{FIFO_AW{1'b0}}, push};
      rd_ptr <= rd_ptr + {{FIFO_AW{1'b0}}, pop};
      underflow <= uf_ev | (underflow & ~clear_underflow);
    end
  // boundary fe only loads; the MSB leaves on the following fe (one-BCLK I2S delay)
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) begin
      sr <= '0;
      hold <= '0;
      bit_cnt <= '0;
      dac_data_export <= 1'b0;
    end else if (left_b | right_b) begin
      sr <= right_b ? hold : pop ? rd_data[2*DATA_WIDTH-1:DATA_WIDTH] : '0;
      hold <= right_b ? hold : pop ? rd_data[DATA_WIDTH-1:0] : '0;
      bit_cnt <= CW'(DATA_WIDTH);
    end else if (fe) begin
      dac_data_export <= (bit_cnt != '0) & sr[DATA_WIDTH-1];
      sr <= sr << 1;
      bit_cnt <= (bit_cnt == '0) ? '0 : bit_cnt - 1'b1;
    end
`ifdef AUDIO_DAC_UNDERFLOW_CNT_EN
  always_ff @(posedge clk_clk or negedge reset_reset_n)
    if (!reset_reset_n) underflow_count <= '0;
    else underflow_count <= uf_ev ? (clear_underflow ? 16'd1 : (&underflow_count) ? underflow_count : underflow_count + 16'd1)
                                  : clear_underflow ? '0 : underflow_count;
`endif
endmodule
